time_keeper: RTL and testbench
==============================

# time_keeper

Parametrised time-of-day counter for the clock datapath. Divides the system clock to a one-second tick and maintains a 24-hour hh:mm:ss time. Adds run/pause, validated time load, 12/24-hour display output, and one-cycle carry pulses that downstream display and timer blocks consume. Sits between the board clock and the display formatter.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: system clock cycles per second. Must be ≥ 1.
- `CNT_W`, default `$clog2(TICK_DIV)` (minimum 1): prescaler counter width.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: 1 = time advances; 0 = prescaler and time hold.
- `h12_mode` in 1: 1 = 12-hour display; 0 = 24-hour display.
- `load_valid` in 1: single-cycle request to load time.
- `load_hh` in 5, `load_mm` in 6, `load_ss` in 6: time to load.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `seconds` out 6, `minutes` out 6, `hours` out 5: current time, hours in 24-hour form (0–23).
- `disp_hours` out 5: hours formatted per `h12_mode`.
- `isPM` out 1: `hours >= 12`.
- `sec_pulse`, `min_pulse`, `hour_pulse`, `day_pulse` out 1: one-cycle carry pulses.
- `alarm_set` in 1, `alarm_hh` in 5, `alarm_mm` in 6, `alarm_on` in 1: alarm programming.
- `alarm_fire` out 1: alarm pulse.

## Operation
- **Reset.** Prescaler, time, alarm registers and all pulses are 0. `alarm_on` latch is 0. `isPM` is 0. `disp_hours` is 12 if `h12_mode`=1, else 0.
- **Prescaler.**
  - `cnt` counts 0..TICK_DIV-1 while `run`=1.
  - `tick` = `run && cnt == TICK_DIV-1`. On a tick, `cnt` returns to 0.
  - When `TICK_DIV`=1, `tick` = `run`.
- **Advance on tick.**
  - `seconds`+1. At 59, seconds wraps to 0 and `minutes`+1.
  - Minutes wrap 59→0 and increment `hours`. Hours wrap 23→0.
- **Carry pulses.** Registered in the same edge as the time update, so each pulse is high in the cycle where the new value is visible:
  - `sec_pulse` on every tick.
  - `min_pulse` when seconds wrap.
  - `hour_pulse` when minutes wrap.
  - `day_pulse` when hours wrap 23→0.
- **Load.**
  - Priority order: `reset` > `load_valid` > `tick`.
  - A valid load (hh ≤ 23, mm ≤ 59, ss ≤ 59) writes the time and clears `cnt` to 0. No carry pulses are generated, and a tick in the same cycle is discarded.
  - An invalid load leaves time and `cnt` unchanged (a coincident tick still advances time) and pulses `load_err` in the next cycle.
- **Display.** `isPM` and `disp_hours` are combinational from `hours` and `h12_mode`.
  - 24-hour mode: `disp_hours` = `hours`.
  - 12-hour mode: 0→12, 1..12 unchanged, 13..23 → hours−12.
- **Width rules.** Internal compares use full port widths. Values outside the ranges above are unreachable except through load, and load rejects them.

## Timing
- Load latency: 1 cycle (values visible in the cycle after `load_valid`).
- Tick-to-update latency: 1 cycle. Pulses are exactly 1 cycle wide.
- Full rollover 23:59:59 + tick → 00:00:00, with all four pulses high in the same cycle.
- `run` deasserted mid-count freezes `cnt`. Counting resumes from the frozen value with no lost or extra tick.
- Reset asserted mid-count: all state is 0 in the next cycle. Any pending pulse is suppressed.

## Configuration
- Macro: `TIME_KEEPER_ALARM_EN`.
- **Defined:**
  - `alarm_set` latches `alarm_hh`, `alarm_mm` and `alarm_on`. Out-of-range alarm values are latched but never match.
  - `alarm_fire` pulses for one cycle, coincident with `min_pulse`, when a tick moves time to alarm_hh:alarm_mm:00 and the latched enable is 1.
  - A load onto the alarm time does not fire.
- **Undefined:** alarm ports remain present, inputs are ignored, `alarm_fire` is tied to 0, and no alarm registers are instantiated.

## Structure
- Package `time_pkg`:
  - constants `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23, `NOON`=12;
  - widths `SEC_W`=6, `MIN_W`=6, `HOUR_W`=5;
  - typedef `time_t` as a packed struct {hh, mm, ss}.
- Sub-module `tick_prescaler` (parameter `TICK_DIV`; ports `clk`, `reset`, `run`, `clear`, `tick`).
- Carry chain, load, display and alarm logic stay in `time_keeper`.

## Test plan
- TICK_DIV=4, reset then `run`=1 for 8 cycles → `sec_pulse` in cycles 4 and 8, `seconds`=2.
- Load 23:59:59, one tick → 00:00:00, `hour_pulse`=`min_pulse`=`day_pulse`=`sec_pulse`=1 in one cycle, `isPM` 1→0.
- Load hh=24 → `load_err` pulses once, time unchanged. Load 12:00:00 in 12-hour mode → `disp_hours`=12, `isPM`=1. Load 13:05:00 → `disp_hours`=1.
- Load in the same cycle as a tick → loaded value exact, `cnt`=0, next `sec_pulse` after TICK_DIV cycles.
- `run` dropped at `cnt`=2 for 10 cycles, then raised → next tick after 1 more cycle. Reset mid-run → all outputs 0.
- With `TIME_KEEPER_ALARM_EN`: alarm 07:30 on, load 07:29:58, 2 ticks → `alarm_fire` with `min_pulse`. Load 07:30:00 directly → no fire. Without the macro → `alarm_fire` stays 0.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: shared widths, limits and the packed time-of-day type for time_keeper.
//   SEC_W/MIN_W/HOUR_W : field widths of seconds, minutes and hours
//   SEC_MAX/MIN_MAX/HOUR_MAX : last legal value of each field before it wraps
//   NOON : first PM hour, also the 12-hour display value for midnight
//   time_t : packed {hh, mm, ss}
package time_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] NOON     = 5'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hh;
        logic [MIN_W-1:0]  mm;
        logic [SEC_W-1:0]  ss;
    } time_t;

endpackage

// File: rtl/time_keeper_tick_prescaler.sv
// tick_prescaler: divides the system clock down to a one-cycle tick every TICK_DIV
// running cycles.
//   clk   : system clock (rising edge)
//   reset : synchronous, active-high; clears the counter
//   run   : 1 = count, 0 = hold the counter where it is
//   clear : restart the count from 0 (a coincident tick is dropped)
//   tick  : combinational, high while run=1 and the counter sits at TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With TICK_DIV=1 CntMax is 0, so the counter never leaves 0 and tick == run.
    assign tick = run && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24-hour hh:mm:ss time-of-day counter driven by a one-second tick.
// Optional alarm compare is built only when TIME_KEEPER_ALARM_EN is defined; otherwise
// the alarm inputs are ignored and alarm_fire is tied low.
//   clk, reset          : system clock, synchronous active-high reset
//   run                 : 1 = time advances, 0 = prescaler and time hold
//   h12_mode            : display format select for disp_hours
//   load_valid/load_*   : one-cycle time load request; load_err pulses on rejection
//   seconds/minutes/hours : current time (hours 0..23)
//   disp_hours, isPM    : combinational display view of hours
//   *_pulse             : one-cycle carry pulses, high with the updated time
//   alarm_*             : alarm programming and one-cycle alarm_fire pulse
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              h12_mode,
    input  logic              load_valid,
    input  logic [HOUR_W-1:0] load_hh,
    input  logic [MIN_W-1:0]  load_mm,
    input  logic [SEC_W-1:0]  load_ss,
    output logic              load_err,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic [HOUR_W-1:0] disp_hours,
    output logic              isPM,
    output logic              sec_pulse,
    output logic              min_pulse,
    output logic              hour_pulse,
    output logic              day_pulse,
    input  logic              alarm_set,
    input  logic [HOUR_W-1:0] alarm_hh,
    input  logic [MIN_W-1:0]  alarm_mm,
    input  logic              alarm_on,
    output logic              alarm_fire
);

    time_t time_q, time_d;
    logic  sec_pulse_q, sec_pulse_d;
    logic  min_pulse_q, min_pulse_d;
    logic  hour_pulse_q, hour_pulse_d;
    logic  day_pulse_q, day_pulse_d;
    logic  load_err_q, load_err_d;
    logic  tick;
    logic  load_ok;

    assign load_ok = load_valid && (load_hh <= HOUR_MAX) && (load_mm <= MIN_MAX) &&
                     (load_ss <= SEC_MAX);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (load_ok),
        .tick  (tick)
    );

    // A valid load wins over the tick; a rejected load lets the tick through.
    always_comb begin
        time_d       = time_q;
        sec_pulse_d  = 1'b0;
        min_pulse_d  = 1'b0;
        hour_pulse_d = 1'b0;
        day_pulse_d  = 1'b0;
        load_err_d   = load_valid && !load_ok;
        if (load_ok) begin
            time_d = '{hh: load_hh, mm: load_mm, ss: load_ss};
        end else if (tick) begin
            sec_pulse_d = 1'b1;
            if (time_q.ss == SEC_MAX) begin
                time_d.ss   = '0;
                min_pulse_d = 1'b1;
                if (time_q.mm == MIN_MAX) begin
                    time_d.mm    = '0;
                    hour_pulse_d = 1'b1;
                    if (time_q.hh == HOUR_MAX) begin
                        time_d.hh   = '0;
                        day_pulse_d = 1'b1;
                    end else begin
                        time_d.hh = time_q.hh + 1'b1;
                    end
                end else begin
                    time_d.mm = time_q.mm + 1'b1;
                end
            end else begin
                time_d.ss = time_q.ss + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q       <= '0;
            sec_pulse_q  <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            time_q       <= time_d;
            sec_pulse_q  <= sec_pulse_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            day_pulse_q  <= day_pulse_d;
            load_err_q   <= load_err_d;
        end
    end

    assign seconds    = time_q.ss;
    assign minutes    = time_q.mm;
    assign hours      = time_q.hh;
    assign sec_pulse  = sec_pulse_q;
    assign min_pulse  = min_pulse_q;
    assign hour_pulse = hour_pulse_q;
    assign day_pulse  = day_pulse_q;
    assign load_err   = load_err_q;

    // 12-hour view: midnight shows as 12, afternoon hours fold down by 12.
    always_comb begin
        disp_hours = time_q.hh;
        if (h12_mode) begin
            if (time_q.hh == '0) begin
                disp_hours = NOON;
            end else if (time_q.hh > NOON) begin
                disp_hours = time_q.hh - NOON;
            end
        end
    end

    assign isPM = (time_q.hh >= NOON);

`ifdef TIME_KEEPER_ALARM_EN
    logic [HOUR_W-1:0] alarm_hh_q, alarm_hh_d;
    logic [MIN_W-1:0]  alarm_mm_q, alarm_mm_d;
    logic              alarm_on_q, alarm_on_d;
    logic              alarm_fire_q, alarm_fire_d;

    // Only a tick landing on hh:mm:00 fires; time_d is always in range, so an
    // out-of-range latched alarm can never match.
    always_comb begin
        alarm_hh_d   = alarm_set ? alarm_hh : alarm_hh_q;
        alarm_mm_d   = alarm_set ? alarm_mm : alarm_mm_q;
        alarm_on_d   = alarm_set ? alarm_on : alarm_on_q;
        alarm_fire_d = tick && !load_ok && alarm_on_q && (time_d.hh == alarm_hh_q) &&
                       (time_d.mm == alarm_mm_q) && (time_d.ss == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hh_q   <= '0;
            alarm_mm_q   <= '0;
            alarm_on_q   <= 1'b0;
            alarm_fire_q <= 1'b0;
        end else begin
            alarm_hh_q   <= alarm_hh_d;
            alarm_mm_q   <= alarm_mm_d;
            alarm_on_q   <= alarm_on_d;
            alarm_fire_q <= alarm_fire_d;
        end
    end

    assign alarm_fire = alarm_fire_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_set, alarm_hh, alarm_mm, alarm_on};
    assign alarm_fire   = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed bench for time_keeper with TICK_DIV=4. A model tracks
// time as seconds-since-midnight plus a cycle phase and is compared against every
// DUT output after each clock edge; literal checks pin the model on key cases.
module tb_time_keeper;

    localparam int TickDiv = 4;
`ifdef TIME_KEEPER_ALARM_EN
    localparam logic AlarmEn = 1'b1;
`else
    localparam logic AlarmEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, run, h12_mode, load_valid;
    logic [4:0] load_hh;
    logic [5:0] load_mm, load_ss;
    logic       load_err;
    logic [5:0] seconds, minutes;
    logic [4:0] hours, disp_hours;
    logic       is_pm;
    logic       sec_pulse, min_pulse, hour_pulse, day_pulse;
    logic       alarm_set, alarm_on, alarm_fire;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;

    always #5 clk = ~clk;

    time_keeper #(
        .TICK_DIV (TickDiv)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .h12_mode   (h12_mode),
        .load_valid (load_valid),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .load_ss    (load_ss),
        .load_err   (load_err),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .disp_hours (disp_hours),
        .isPM       (is_pm),
        .sec_pulse  (sec_pulse),
        .min_pulse  (min_pulse),
        .hour_pulse (hour_pulse),
        .day_pulse  (day_pulse),
        .alarm_set  (alarm_set),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm_on   (alarm_on),
        .alarm_fire (alarm_fire)
    );

    // Model state: time as seconds since midnight, prescaler phase in cycles.
    bit m_valid = 1'b0;
    int m_cnt, m_tod;
    bit m_sec, m_min, m_hour, m_day, m_err, m_fire;
    bit m_al_on;
    int m_al_h, m_al_m;
    bit m_tk, m_ok;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_cnt = 0; m_tod = 0;
            m_sec = 0; m_min = 0; m_hour = 0; m_day = 0; m_err = 0; m_fire = 0;
            m_al_on = 0; m_al_h = 0; m_al_m = 0;
        end else begin
            m_tk = run && (m_cnt == TickDiv - 1);
            m_ok = load_valid && (load_hh < 24) && (load_mm < 60) && (load_ss < 60);
            m_sec = 0; m_min = 0; m_hour = 0; m_day = 0; m_fire = 0;
            m_err = load_valid && !m_ok;
            if (m_ok) begin
                m_tod = int'(load_hh) * 3600 + int'(load_mm) * 60 + int'(load_ss);
                m_cnt = 0;
            end else if (m_tk) begin
                m_cnt  = 0;
                m_tod  = (m_tod + 1) % 86400;
                m_sec  = 1;
                m_min  = (m_tod % 60) == 0;
                m_hour = (m_tod % 3600) == 0;
                m_day  = m_tod == 0;
                if (AlarmEn)
                    m_fire = m_al_on && (m_al_h < 24) && (m_al_m < 60) &&
                             (m_tod == m_al_h * 3600 + m_al_m * 60);
            end else if (run) begin
                m_cnt = m_cnt + 1;
            end
            if (AlarmEn && alarm_set) begin
                m_al_on = alarm_on;
                m_al_h  = int'(alarm_hh);
                m_al_m  = int'(alarm_mm);
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int h, dh;
        h  = m_tod / 3600;
        dh = !h12_mode ? h : ((h % 12 == 0) ? 12 : h % 12);
        if (!m_valid) return;
        chk("seconds", 32'(seconds), 32'(m_tod % 60));
        chk("minutes", 32'(minutes), 32'((m_tod / 60) % 60));
        chk("hours", 32'(hours), 32'(h));
        chk("disp_hours", 32'(disp_hours), 32'(dh));
        chk("isPM", 32'(is_pm), 32'(m_tod >= 43200));
        chk("sec_pulse", 32'(sec_pulse), 32'(m_sec));
        chk("min_pulse", 32'(min_pulse), 32'(m_min));
        chk("hour_pulse", 32'(hour_pulse), 32'(m_hour));
        chk("day_pulse", 32'(day_pulse), 32'(m_day));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("alarm_fire", 32'(alarm_fire), 32'(m_fire));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int hh, input int mm, input int ss);
        load_valid = 1'b1;
        load_hh = 5'(hh); load_mm = 6'(mm); load_ss = 6'(ss);
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; h12_mode = 1'b0; load_valid = 1'b0;
        load_hh = '0; load_mm = '0; load_ss = '0;
        alarm_set = 1'b0; alarm_hh = '0; alarm_mm = '0; alarm_on = 1'b0;
        steps(2);
        chk("rst_hours", 32'(hours), 0);
        chk("rst_seconds", 32'(seconds), 0);
        chk("rst_disp24", 32'(disp_hours), 0);
        h12_mode = 1'b1; #1;
        chk("rst_disp12", 32'(disp_hours), 12);
        h12_mode = 1'b0;

        // Prescaler: pulses on the 4th and 8th running cycle.
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("div4_sec_pulse", 32'(sec_pulse), 32'((i == 3) || (i == 7)));
        end
        chk("div4_seconds", 32'(seconds), 2);

        // Full-day rollover.
        do_load(23, 59, 59);
        chk("pre_roll_isPM", 32'(is_pm), 1);
        steps(3);
        chk("pre_roll_sec", 32'(seconds), 59);
        step();
        chk("roll_hours", 32'(hours), 0);
        chk("roll_minutes", 32'(minutes), 0);
        chk("roll_pulses", 32'({sec_pulse, min_pulse, hour_pulse, day_pulse}), 32'hf);
        chk("roll_isPM", 32'(is_pm), 0);

        // Rejected load, then display formatting.
        do_load(24, 0, 0);
        chk("bad_load_err", 32'(load_err), 1);
        chk("bad_load_hours", 32'(hours), 0);
        step();
        chk("bad_load_err_drop", 32'(load_err), 0);
        h12_mode = 1'b1;
        do_load(12, 0, 0);
        chk("noon_disp", 32'(disp_hours), 12);
        chk("noon_isPM", 32'(is_pm), 1);
        do_load(13, 5, 0);
        chk("h13_disp", 32'(disp_hours), 1);
        for (int h = 0; h < 24; h++) begin
            h12_mode = h[0];
            do_load(h, 7, 9);
        end
        h12_mode = 1'b0;

        // Load coinciding with a tick: load wins, count restarts.
        do_load(10, 20, 30);
        steps(3);
        do_load(1, 2, 3);
        chk("ld_tick_ss", 32'(seconds), 3);
        chk("ld_tick_hh", 32'(hours), 1);
        chk("ld_tick_pulse", 32'(sec_pulse), 0);
        steps(3);
        chk("ld_tick_wait", 32'(sec_pulse), 0);
        step();
        chk("ld_tick_next", 32'(sec_pulse), 1);
        chk("ld_tick_next_ss", 32'(seconds), 4);

        // Rejected load with a coincident tick still advances.
        steps(3);
        do_load(5, 60, 0);
        chk("bad_tick_err", 32'(load_err), 1);
        chk("bad_tick_ss", 32'(seconds), 5);

        // Pause at cnt=2 for 10 cycles.
        steps(2);
        run = 1'b0;
        steps(10);
        chk("pause_ss", 32'(seconds), 5);
        run = 1'b1;
        step();
        chk("resume_first", 32'(sec_pulse), 0);
        step();
        chk("resume_tick", 32'(sec_pulse), 1);
        chk("resume_ss", 32'(seconds), 6);

        // Alarm at 07:30.
        alarm_set = 1'b1; alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_on = 1'b1;
        step();
        alarm_set = 1'b0;
        do_load(7, 29, 58);
        steps(8);
        chk("alarm_min", 32'(min_pulse), 1);
        chk("alarm_fire_0730", 32'(alarm_fire), 32'(AlarmEn));
        do_load(7, 30, 0);
        chk("alarm_load_nofire", 32'(alarm_fire), 0);
        steps(5);

        // Reset mid-run clears time and alarm enable.
        reset = 1'b1;
        step();
        chk("mid_rst_hh", 32'(hours), 0);
        chk("mid_rst_ss", 32'(seconds), 0);
        chk("mid_rst_pulse", 32'(sec_pulse), 0);
        h12_mode = 1'b1; #1;
        chk("mid_rst_disp12", 32'(disp_hours), 12);
        reset = 1'b0;
        do_load(7, 29, 59);
        steps(6);
        chk("alarm_after_rst", 32'(alarm_fire), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
